// File: rtl/sprite_bank.sv
// Memory-mapped bank of auto-moving sprite registers with a shared motion tick.
// Optional collision detection and interrupt are built when SPRITE_COLLISION_EN is defined.
module sprite_bank #(
   parameter int          NUM_SPRITES = 4,
   parameter logic [11:0] BASE_ADDR   = 12'hd00,
   parameter int          X_MAX       = 624,
   parameter int          Y_MAX       = 464,
   parameter int          TICK_DIV    = 33554432
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [11:0]               address,
   input  logic [15:0]               data_out,
   input  logic                      memwt,
   output logic [15:0]               rd_data,
   output logic                      hit,
   output logic [16*NUM_SPRITES-1:0] sprite_x,
   output logic [16*NUM_SPRITES-1:0] sprite_y,
   output logic                      irq
);

   localparam int             CW         = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  TICK_LAST  = CW'(TICK_DIV - 1);
   localparam logic [12:0]    STATUS_OFF = 13'(4 * NUM_SPRITES);
   localparam logic [15:0]    X_LIM      = 16'(X_MAX);
   localparam logic [15:0]    Y_LIM      = 16'(Y_MAX);

   // One axis step; returns {direction, position}. A zero step leaves the axis untouched.
   function automatic logic [16:0] move_axis(input logic [15:0] pos, input logic [7:0] d,
                                             input logic dir, input logic [15:0] lim);
      logic [16:0] sum;
      logic [16:0] res;
      sum = {1'b0, pos} + {9'b0, d};
      if (d == 8'd0) begin
         res = {dir, pos};
      end else if (dir) begin
         res = (sum >= {1'b0, lim}) ? {1'b0, lim} : {1'b1, sum[15:0]};
      end else begin
         res = (pos <= {8'b0, d}) ? {1'b1, 16'd0} : {1'b0, pos - {8'b0, d}};
      end
      return res;
   endfunction

   logic [12:0]            off_s;
   logic                   hit_s;
   logic                   spr_sel_s;
   logic                   wr_s;
   logic [2:0]             idx_s;
   logic [CW-1:0]          cnt_r;
   logic                   tick_s;
   logic [15:0]            x_r    [NUM_SPRITES];
   logic [15:0]            y_r    [NUM_SPRITES];
   logic [15:0]            step_r [NUM_SPRITES];
   logic [3:0]             ctrl_r [NUM_SPRITES];
   logic [16:0]            mx_s   [NUM_SPRITES];
   logic [16:0]            my_s   [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] wr_spr_s;
   logic [NUM_SPRITES-1:0] status_s;
   logic [15:0]            sx_s, sy_s, ss_s;
   logic [3:0]             sc_s;
   logic [15:0]            rd_s;

   // Borrow in bit 12 flags addresses below the window.
   assign off_s     = {1'b0, address} - {1'b0, BASE_ADDR};
   assign hit_s     = ~off_s[12] && (off_s <= STATUS_OFF);
   assign spr_sel_s = ~off_s[12] && (off_s < STATUS_OFF);
   assign idx_s     = off_s[4:2];
   assign wr_s      = memwt && hit_s;
   assign tick_s    = (cnt_r == TICK_LAST);

   // Per-sprite write decode and next-position candidates.
   always_comb begin
      wr_spr_s = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         wr_spr_s[i] = wr_s && spr_sel_s && (idx_s == 3'(i));
         mx_s[i]     = move_axis(x_r[i], step_r[i][7:0], ctrl_r[i][1], X_LIM);
         my_s[i]     = move_axis(y_r[i], step_r[i][15:8], ctrl_r[i][2], Y_LIM);
      end
   end

   // Motion tick divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= tick_s ? '0 : cnt_r + CW'(1);
      end
   end

   // Sprite registers: a CPU write to a sprite suppresses its motion on that tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_r[i]    <= 16'h0000;
            y_r[i]    <= 16'h0000;
            ctrl_r[i] <= 4'h0;
            step_r[i] <= 16'h0101;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr_spr_s[i]) begin
               case (off_s[1:0])
                  2'd0:    x_r[i]    <= (data_out > X_LIM) ? X_LIM : data_out;
                  2'd1:    y_r[i]    <= (data_out > Y_LIM) ? Y_LIM : data_out;
                  2'd2:    ctrl_r[i] <= data_out[3:0];
                  default: step_r[i] <= data_out;
               endcase
            end else if (tick_s && ctrl_r[i][0]) begin
               x_r[i]       <= mx_s[i][15:0];
               ctrl_r[i][1] <= mx_s[i][16];
               y_r[i]       <= my_s[i][15:0];
               ctrl_r[i][2] <= my_s[i][16];
            end
         end
      end
   end

`ifdef SPRITE_COLLISION_EN
   function automatic logic near(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] d;
      d = (a > b) ? (a - b) : (b - a);
      return d < 16'd16;
   endfunction

   logic                   tick_d_r;
   logic                   irq_r;
   logic [NUM_SPRITES-1:0] status_r;
   logic [NUM_SPRITES-1:0] coll_s;
   logic [NUM_SPRITES-1:0] clr_s;
   logic [NUM_SPRITES-1:0] mask_s;

   // Pairwise proximity test and STATUS clear decode.
   always_comb begin
      coll_s = '0;
      mask_s = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         mask_s[i] = ctrl_r[i][3];
         for (int j = 0; j < NUM_SPRITES; j++) begin
            coll_s[i] = coll_s[i] | ((i != j) && near(x_r[i], x_r[j]) && near(y_r[i], y_r[j]));
         end
      end
      clr_s = (wr_s && !spr_sel_s) ? data_out[NUM_SPRITES-1:0] : '0;
   end

   // Sticky collision flags, sampled on positions settled by the previous tick; set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_d_r <= 1'b0;
         status_r <= '0;
         irq_r    <= 1'b0;
      end else begin
         tick_d_r <= tick_s;
         status_r <= (status_r & ~clr_s) | (tick_d_r ? coll_s : '0);
         irq_r    <= |(status_r & mask_s);
      end
   end

   assign status_s = status_r;
   assign irq      = irq_r;
`else
   assign status_s = '0;
   assign irq      = 1'b0;
`endif

   // Zero-latency read multiplexer.
   always_comb begin
      sx_s = 16'h0000;
      sy_s = 16'h0000;
      sc_s = 4'h0;
      ss_s = 16'h0000;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         sx_s = (idx_s == 3'(i)) ? x_r[i]    : sx_s;
         sy_s = (idx_s == 3'(i)) ? y_r[i]    : sy_s;
         sc_s = (idx_s == 3'(i)) ? ctrl_r[i] : sc_s;
         ss_s = (idx_s == 3'(i)) ? step_r[i] : ss_s;
      end
      if (spr_sel_s) begin
         case (off_s[1:0])
            2'd0:    rd_s = sx_s;
            2'd1:    rd_s = sy_s;
            2'd2:    rd_s = {12'h000, sc_s};
            default: rd_s = ss_s;
         endcase
      end else if (hit_s) begin
         rd_s = 16'(status_s);
      end else begin
         rd_s = 16'h0000;
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
      assign sprite_x[16*g +: 16] = x_r[g];
      assign sprite_y[16*g +: 16] = y_r[g];
   end

   assign rd_data = rd_s;
   assign hit     = hit_s;

endmodule

// File: tb/tb_sprite_bank.sv
// Bench for sprite_bank (2 sprites, TICK_DIV=4): behavioural register/motion model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sprite_bank;
   localparam int          NS   = 2;
   localparam int          TD   = 4;
   localparam int          XM   = 624;
   localparam int          YM   = 464;
   localparam logic [11:0] BASE = 12'hd00;
   localparam logic [11:0] AX0 = 12'hd00, AY0 = 12'hd01, AC0 = 12'hd02, AS0 = 12'hd03;
   localparam logic [11:0] AX1 = 12'hd04, AY1 = 12'hd05, AC1 = 12'hd06, AS1 = 12'hd07;
   localparam logic [11:0] AST = 12'hd08;

   logic        clk;
   logic        rst_n;
   logic [11:0] address;
   logic [15:0] data_out;
   logic        memwt;
   logic [15:0] rd_data;
   logic        hit;
   logic [31:0] sprite_x;
   logic [31:0] sprite_y;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   sprite_bank #(.NUM_SPRITES(NS), .BASE_ADDR(BASE), .X_MAX(XM), .Y_MAX(YM), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .address(address), .data_out(data_out), .memwt(memwt),
      .rd_data(rd_data), .hit(hit), .sprite_x(sprite_x), .sprite_y(sprite_y), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_x[NS], m_y[NS], m_ctrl[NS], m_step[NS];
   int m_status, m_cnt, m_cpend, m_irq;

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic int ax_pos(input int p, input int d, input int dir, input int lim);
      if (d == 0) return p;
      if (dir != 0) return (p + d >= lim) ? lim : p + d;
      return (p <= d) ? 0 : p - d;
   endfunction

   function automatic int ax_dir(input int p, input int d, input int dir, input int lim);
      if (d == 0) return dir;
      if (dir != 0) return (p + d >= lim) ? 0 : 1;
      return (p <= d) ? 1 : 0;
   endfunction

   function automatic logic [15:0] exp_rd(input logic [11:0] a);
      int off;
      off = int'(a) - int'(BASE);
      if (off < 0 || off > 4 * NS) return 16'h0;
      if (off == 4 * NS) return 16'(m_status);
      case (off % 4)
         0: return 16'(m_x[off / 4]);
         1: return 16'(m_y[off / 4]);
         2: return 16'(m_ctrl[off / 4]);
         default: return 16'(m_step[off / 4]);
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int off, s, d, set, clr, msk, nirq, px, py, dx, dy, dirx, diry;
      bit tk, wr;
      if (!rst_n) begin
         for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_ctrl[i] = 0; m_step[i] = 16'h0101;
         end
         m_status = 0; m_cnt = 0; m_cpend = 0; m_irq = 0;
      end else begin
         tk  = (m_cnt == TD - 1);
         off = int'(address) - int'(BASE);
         wr  = memwt && off >= 0 && off <= 4 * NS;
         d   = int'(data_out);
         set = 0;
         msk = 0;
         for (int i = 0; i < NS; i++) msk |= ((m_ctrl[i] >> 3) & 1) << i;
`ifdef SPRITE_COLLISION_EN
         if (m_cpend != 0)
            for (int i = 0; i < NS; i++)
               for (int j = 0; j < NS; j++)
                  if (i != j && absd(m_x[i], m_x[j]) < 16 && absd(m_y[i], m_y[j]) < 16)
                     set |= 1 << i;
         nirq = ((m_status & msk) != 0) ? 1 : 0;
`else
         nirq = 0;
`endif
         for (int i = 0; i < NS; i++) begin
            if (tk && (m_ctrl[i] & 1) != 0 && !(wr && off < 4 * NS && off / 4 == i)) begin
               px = m_x[i]; py = m_y[i];
               dx = m_step[i] & 255; dy = (m_step[i] >> 8) & 255;
               dirx = (m_ctrl[i] >> 1) & 1; diry = (m_ctrl[i] >> 2) & 1;
               m_x[i] = ax_pos(px, dx, dirx, XM);
               m_y[i] = ax_pos(py, dy, diry, YM);
               m_ctrl[i] = (m_ctrl[i] & 9) | (ax_dir(px, dx, dirx, XM) << 1)
                                           | (ax_dir(py, dy, diry, YM) << 2);
            end
         end
         if (wr && off < 4 * NS) begin
            s = off / 4;
            case (off % 4)
               0: m_x[s] = (d > XM) ? XM : d;
               1: m_y[s] = (d > YM) ? YM : d;
               2: m_ctrl[s] = d & 15;
               default: m_step[s] = d;
            endcase
         end
         clr = (wr && off == 4 * NS) ? (d & ((1 << NS) - 1)) : 0;
`ifdef SPRITE_COLLISION_EN
         m_status = (m_status & ~clr) | set;
`else
         m_status = 0 & clr;
`endif
         m_cpend = tk ? 1 : 0;
         m_cnt   = tk ? 0 : m_cnt + 1;
         m_irq   = nirq;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [31:0] ex, ey;
      int off;
      if (rst_n) begin
         for (int i = 0; i < NS; i++) begin
            ex[16*i +: 16] = 16'(m_x[i]);
            ey[16*i +: 16] = 16'(m_y[i]);
         end
         off = int'(address) - int'(BASE);
         check("hit", {31'b0, hit}, {31'b0, (off >= 0 && off <= 4 * NS)});
         check("rd_data", {16'b0, rd_data}, {16'b0, exp_rd(address)});
         check("sprite_x", sprite_x, ex);
         check("sprite_y", sprite_y, ey);
         check("irq", {31'b0, irq}, 32'(m_irq));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wr(input logic [11:0] a, input logic [15:0] d);
      @(negedge clk); #1;
      address = a; data_out = d; memwt = 1'b1;
      @(negedge clk); #1;
      memwt = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [11:0] a, input logic [15:0] exp);
      address = a; #1;
      check(nm, {16'b0, rd_data}, {16'b0, exp});
   endtask

   task automatic wait_move(input int s, input bit yaxis);
      logic [15:0] old, cur;
      bit done;
      old  = yaxis ? sprite_y[16*s +: 16] : sprite_x[16*s +: 16];
      done = 1'b0;
      for (int n = 0; n < 30 && !done; n++) begin
         @(posedge clk); #1;
         cur = yaxis ? sprite_y[16*s +: 16] : sprite_x[16*s +: 16];
         if (cur != old) done = 1'b1;
      end
      if (!done) check("move_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      logic [15:0] x0_before;
      clk = 1'b0; rst_n = 1'b1; address = 12'h000; data_out = 16'h0; memwt = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b1;

      // Reset mid-count clears registers asynchronously and restarts the divider.
      wr(AX0, 16'd50);
      wr(AS0, 16'h0303);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0; address = AS0;
      #1;
      check("rst_x", sprite_x, 32'h0);
      check("rst_step", {16'b0, rd_data}, 32'h0101);
      check("rst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk); #1;
      rst_n = 1'b1; address = AC0; data_out = 16'h0003; memwt = 1'b1;
      @(posedge clk); #1 memwt = 1'b0;
      n = 1;
      while (sprite_x[15:0] == 16'd0 && n < 20) begin
         @(posedge clk); #1 n++;
      end
      check("first_tick_cycles", 32'(n), 32'd4);
      check("first_tick_x", {16'b0, sprite_x[15:0]}, 32'd1);

      // Clamping and window edges.
      wr(AC0, 16'h0000);
      wr(AX0, 16'd700);
      rd_chk("clamp_x", AX0, 16'd624);
      wr(AY0, 16'hffff);
      rd_chk("clamp_y", AY0, 16'd464);
      rd_chk("outside_hi", BASE + 12'd9, 16'h0);
      check("hit_outside_hi", {31'b0, hit}, 32'h0);
      rd_chk("outside_lo", BASE - 12'd1, 16'h0);
      check("hit_outside_lo", {31'b0, hit}, 32'h0);

      // Right-edge bounce.
      wr(AX0, 16'd620);
      wr(AS0, 16'h0008);
      wr(AC0, 16'h0003);
      wait_move(0, 1'b0);
      check("bounce_x", {16'b0, sprite_x[15:0]}, 32'd624);
      rd_chk("bounce_ctrl", AC0, 16'h0001);
      wait_move(0, 1'b0);
      check("bounce_x2", {16'b0, sprite_x[15:0]}, 32'd616);

      // Left-edge bounce.
      wr(AC0, 16'h0000);
      wr(AX0, 16'd3);
      wr(AS0, 16'h0005);
      wr(AC0, 16'h0001);
      wait_move(0, 1'b0);
      check("left_x", {16'b0, sprite_x[15:0]}, 32'd0);
      rd_chk("left_ctrl", AC0, 16'h0003);
      wait_move(0, 1'b0);
      check("left_x2", {16'b0, sprite_x[15:0]}, 32'd5);

      // Bottom-edge bounce on sprite 1.
      wr(AC1, 16'h0000);
      wr(AY1, 16'd460);
      wr(AS1, 16'h0600);
      wr(AC1, 16'h0005);
      wait_move(1, 1'b1);
      check("bottom_y", {16'b0, sprite_y[31:16]}, 32'd464);
      rd_chk("bottom_ctrl", AC1, 16'h0001);

      // A write on the tick cycle freezes only the written sprite.
      wr(AC0, 16'h0000);
      wr(AC1, 16'h0000);
      wr(AX0, 16'd0);
      wr(AS0, 16'h0001);
      wr(AX1, 16'd50);
      wr(AS1, 16'h0002);
      wr(AC0, 16'h0003);
      wr(AC1, 16'h0003);
      wait_move(0, 1'b0);
      x0_before = sprite_x[15:0];
      repeat (3) @(posedge clk);
      #1 address = AX1; data_out = 16'd100; memwt = 1'b1;
      @(posedge clk); #1 memwt = 1'b0;
      check("prio_x1", {16'b0, sprite_x[31:16]}, 32'd100);
      check("prio_x0", {16'b0, sprite_x[15:0]}, 32'(x0_before) + 32'd1);

      // Collision: separate, clear, then overlap.
      wr(AC0, 16'h0000);
      wr(AC1, 16'h0000);
      wr(AX1, 16'd400);
      repeat (10) @(posedge clk);
      wr(AST, 16'h0003);
      rd_chk("status_cleared", AST, 16'h0000);
      wr(AY1, 16'd108);
      wr(AY0, 16'd100);
      wr(AX0, 16'd100);
      wr(AC0, 16'h0008);
      wr(AX1, 16'd110);
`ifdef SPRITE_COLLISION_EN
      address = AST;
      n = 0;
      do begin
         @(posedge clk); #1 n++;
      end while (rd_data == 16'h0 && n < 20);
      check("coll_status", {16'b0, rd_data}, 32'h3);
      @(posedge clk); #1;
      check("coll_irq", {31'b0, irq}, 32'h1);
      wr(AX1, 16'd200);
      wr(AST, 16'h0001);
      repeat (2) @(posedge clk);
      #1;
      check("coll_irq_clear", {31'b0, irq}, 32'h0);
      rd_chk("coll_status_after", AST, 16'h0002);
`else
      repeat (12) @(posedge clk);
      #1;
      rd_chk("nocoll_status", AST, 16'h0000);
      check("nocoll_irq", {31'b0, irq}, 32'h0);
      wr(AST, 16'hffff);
      rd_chk("nocoll_status_wr", AST, 16'h0000);
`endif
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sprite_bank.md
SPRITE_BANK -- requirements
Module: sprite_bank

Interface
REQ-001 Parameter NUM_SPRITES, default 4: number of independent sprite channels, 1..8.
REQ-002 Parameter BASE_ADDR, default 12'hd00: base of the register window, 4*NUM_SPRITES+1 words.
REQ-003 Parameter X_MAX, default 624: largest legal X coordinate.
REQ-004 Parameter Y_MAX, default 464: largest legal Y coordinate.
REQ-005 Parameter TICK_DIV, default 33554432: clk cycles per motion tick, >=2.
REQ-006 Port clk, input, 1: sole clock, all state on rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port address, input, 12: CPU address.
REQ-009 Port data_out, input, 16: CPU write data.
REQ-010 Port memwt, input, 1: CPU write strobe.
REQ-011 Port rd_data, output, 16: read data for the CPU input multiplexer.
REQ-012 Port hit, output, 1: address falls inside the register window.
REQ-013 Port sprite_x, output, 16*NUM_SPRITES: packed X coordinates, sprite 0 in bits [15:0].
REQ-014 Port sprite_y, output, 16*NUM_SPRITES: packed Y coordinates, same packing.
REQ-015 Port irq, output, 1: level interrupt to the CPU INT input.

Function
REQ-016 Sprite i registers sit at BASE_ADDR+4i:
- +0 X
- +1 Y
- +2 CTRL: bit0 AUTO, bit1 RIGHT, bit2 DOWN, bit3 IRQ_MASK, other bits read 0
- +3 STEP: [7:0] dx, [15:8] dy
REQ-017 STATUS sits at BASE_ADDR+4*NUM_SPRITES and holds one sticky collision bit per sprite in bits [NUM_SPRITES-1:0].
REQ-018 rd_data and hit are combinational from address, with zero latency. Outside the window, hit=0 and rd_data=0.
REQ-019 A write takes effect at the rising edge where memwt=1 and hit=1.
REQ-020 X writes clamp: values >X_MAX store X_MAX. Y writes clamp likewise to Y_MAX.
REQ-021 The tick counter counts 0..TICK_DIV-1 and wraps. A one-cycle tick pulse fires when the count equals TICK_DIV-1.
REQ-022 On tick, each AUTO=1 sprite with RIGHT=1 moves as follows:
- x+dx >= X_MAX: x <= X_MAX and RIGHT <= 0
- otherwise: x <= x+dx
REQ-023 On tick, each AUTO=1 sprite with RIGHT=0 moves as follows:
- x <= dx: x <= 0 and RIGHT <= 1
- otherwise: x <= x-dx
REQ-024 Y motion follows the same rule using DOWN, dy and Y_MAX.
REQ-025 Addition is 17-bit so the result never wraps. dx=0 or dy=0 on an axis means no motion on that axis.
REQ-026 A CPU write to any register of sprite i on a tick cycle wins. Sprite i does not move that tick, and the other sprites move normally.
REQ-027 A write to CTRL clears no state other than CTRL itself.

Reset
REQ-028 While rst_n=0, the following reset immediately, regardless of clk:
- all X, Y and CTRL registers to 0
- STEP to 16'h0101
- STATUS to 0
- tick counter to 0
- irq to 0
REQ-029 A reset asserted mid-tick cancels the pending motion. After release, the first tick occurs TICK_DIV cycles later.
REQ-030 Reset deassertion takes effect at the first rising clk edge with rst_n=1.

Configuration
REQ-031 Macro SPRITE_COLLISION_EN controls collision detection.
REQ-032 With SPRITE_COLLISION_EN defined, on the cycle after each tick, for every pair i!=j with |xi-xj|<16 and |yi-yj|<16, STATUS bits i and j set.
REQ-033 With SPRITE_COLLISION_EN defined, writing 1 to a STATUS bit clears it. If a clear and a set coincide, the set wins.
REQ-034 With SPRITE_COLLISION_EN defined, irq = OR over i of (STATUS[i] AND IRQ_MASK[i]), registered, with one cycle latency.
REQ-035 Without SPRITE_COLLISION_EN, STATUS reads 0, writes to STATUS are ignored, irq is constant 0, and no comparator logic is synthesised.

Verification
REQ-036 Reset: NUM_SPRITES=2, rst_n=0 pulse mid-count -> all coordinates 0, STEP reads 16'h0101, irq=0, first tick exactly TICK_DIV cycles after release.
REQ-037 Clamp: write X=700 to sprite 0 -> reads 624. Write Y=16'hffff -> reads 464.
REQ-038 Bounce: TICK_DIV=4, x=620, dx=8, RIGHT=1, AUTO=1 -> after one tick x=624, RIGHT=0. After the next tick x=616.
REQ-039 Left edge: x=3, dx=5, RIGHT=0 -> after one tick x=0, RIGHT=1. After the next tick x=5.
REQ-040 Write priority: write X=100 to sprite 1 on the tick cycle -> X=100, sprite 1 does not move, sprite 0 moves normally.
REQ-041 Collision (SPRITE_COLLISION_EN): sprites at (100,100) and (110,108), IRQ_MASK0=1 -> STATUS=2'b11 the cycle after the tick, irq=1 one cycle later. Write 1 to bit 0 with sprites separated -> irq=0.
